// File: rtl/ysyx_24100006_lsu_axil_master_if.sv
// Bundles the MEM-stage request/response port and the AXI-Lite initiator channels of the LSU.
interface ysyx_24100006_lsu_axil_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] axi_araddr;
    logic              axi_arvalid;
    logic              axi_arready;
    logic [DATA_W-1:0] axi_rdata;
    logic [1:0]        axi_rresp;
    logic              axi_rvalid;
    logic              axi_rready;
    logic [ADDR_W-1:0] axi_awaddr;
    logic              axi_awvalid;
    logic              axi_awready;
    logic [DATA_W-1:0] axi_wdata;
    logic [7:0]        axi_wstrb;
    logic              axi_wvalid;
    logic              axi_wready;
    logic [1:0]        axi_bresp;
    logic              axi_bvalid;
    logic              axi_bready;

    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output axi_araddr, axi_arvalid, axi_rready,
        input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  axi_araddr, axi_arvalid, axi_rready,
        output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid
    );
endinterface

// File: rtl/ysyx_24100006_lsu_axil_master.sv
// LSU AXI-Lite initiator: one load/store at a time with lane alignment and load extension.
// Optional macro YSYX_24100006_LSU_ALIGN_CHECK_EN rejects misaligned half/word accesses without bus traffic.
module ysyx_24100006_lsu_axil_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic reset,
    ysyx_24100006_lsu_axil_master_if.master bus
);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, RESP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              aw_done, w_done;
    logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;

    function automatic logic [3:0] lane_strb(logic [1:0] size, logic [1:0] off);
        case (size)
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Half lanes are picked by off[1] only, so offset 1 and 3 fall back to the aligned half.
    function automatic logic [31:0] extract_load(logic [31:0] data, logic [1:0] size,
                                                 logic [1:0] off, logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = data[8*off +: 8];
        h = data[16*off[1] +: 16];
        case (size)
            2'd0:    return uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return data;
        endcase
    endfunction

`ifdef YSYX_24100006_LSU_ALIGN_CHECK_EN
    function automatic logic misaligned(logic [1:0] size, logic [1:0] off);
        return (size == 2'd1 && off[0]) || (size[1] && off != 2'd0);
    endfunction
`endif

    assign ar_hs = (state == RADDR) && bus.axi_arready;
    assign r_hs  = (state == RDATA) && bus.axi_rvalid;
    assign aw_hs = (state == WRITE) && !aw_done && bus.axi_awready;
    assign w_hs  = (state == WRITE) && !w_done && bus.axi_wready;
    assign b_hs  = (state == WRESP) && bus.axi_bvalid;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
`ifdef YSYX_24100006_LSU_ALIGN_CHECK_EN
                    if (misaligned(bus.req_size, bus.req_addr[1:0])) state_nxt = RESP;
                    else
`endif
                    state_nxt = bus.req_wen ? WRITE : RADDR;
                end
            end
            RADDR:   if (ar_hs) state_nxt = RDATA;
            RDATA:   if (r_hs) state_nxt = RESP;
            WRITE:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WRESP;
            WRESP:   if (b_hs) state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready   = (state == IDLE);
        bus.resp_valid  = (state == RESP);
        bus.resp_rdata  = rdata_q;
        bus.resp_err    = err_q;
        bus.axi_araddr  = addr_q;
        bus.axi_arvalid = (state == RADDR);
        bus.axi_rready  = (state == RDATA);
        bus.axi_awaddr  = addr_q;
        bus.axi_awvalid = (state == WRITE) && !aw_done;
        bus.axi_wdata   = wdata_q;
        bus.axi_wstrb   = {4'b0000, wstrb_q};
        bus.axi_wvalid  = (state == WRITE) && !w_done;
        bus.axi_bready  = (state == WRESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        size_q  <= bus.req_size;
                        uns_q   <= bus.req_unsigned;
                        wdata_q <= bus.req_wdata << {bus.req_addr[1:0], 3'b000};
                        wstrb_q <= lane_strb(bus.req_size, bus.req_addr[1:0]);
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
`ifdef YSYX_24100006_LSU_ALIGN_CHECK_EN
                        if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
                            err_q <= 1'b1;
                            $display("Error: misaligned access");
                        end
`endif
                    end
                end
                RDATA: begin
                    if (r_hs) begin
                        rdata_q <= extract_load(bus.axi_rdata, size_q, addr_q[1:0], uns_q);
                        err_q   <= (bus.axi_rresp != 2'b00);
                    end
                end
                WRITE: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs) w_done <= 1'b1;
                end
                WRESP: begin
                    if (b_hs) begin
                        rdata_q <= '0;
                        err_q   <= (bus.axi_bresp != 2'b00);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
